// File: rtl/eq_pkg.sv
// Shared constants, FSM state type and output saturation for the equalizer band scheduler.
package eq_pkg;
  localparam int N_BANDS   = 8;
  localparam int DATA_W    = 16;
  localparam int GAIN_W    = 8;
  localparam int ACC_W     = 28;
  localparam int BAND_W    = 3;
  localparam int TIMEOUT   = 63;
  localparam int WAIT_W    = 6;
  localparam int GAIN_FRAC = 6;
  localparam int PROD_W    = DATA_W + GAIN_W + 1;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'h40;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;
  localparam logic signed [ACC_W-1:0]  ACC_HI  = 28'sd32767;
  localparam logic signed [ACC_W-1:0]  ACC_LO  = -28'sd32768;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_t;

  // Drop the Q2.6 gain fraction (truncating toward -inf), then clamp to sfix16.
  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> GAIN_FRAC;
    if (s > ACC_HI)
      return SAT_MAX;
    else if (s < ACC_LO)
      return SAT_MIN;
    else
      return DATA_W'(s);
  endfunction
endpackage

// File: rtl/eq_gain_acc.sv
// Gain multiply, frame accumulator and shift/saturate output register.
module eq_gain_acc
  import eq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     add_en,
  input  logic                     emit,
  input  logic signed [DATA_W-1:0] sample,
  input  logic [GAIN_W-1:0]        gain,
  output logic signed [DATA_W-1:0] out_data
);
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic signed [PROD_W-1:0] product;

  // Gain is unsigned, so a zero MSB keeps it positive in the signed multiply.
  assign product = PROD_W'(sample) * PROD_W'($signed({1'b0, gain}));

  always_comb begin
    acc_next = acc_reg;
    if (clr)
      acc_next = '0;
    else if (add_en)
      acc_next = acc_reg + ACC_W'(product);
  end

  // emit coincides with the last band's add, so the output uses the updated sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg  <= '0;
      out_data <= '0;
    end else begin
      acc_reg <= acc_next;
      if (emit)
        out_data <= saturate(acc_next);
    end
  end
endmodule

// File: rtl/eq_band_scheduler.sv
// Sequences one shared filter core across all bands per sample; owns gains, watchdog and error flags.
module eq_band_scheduler
  import eq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              core_start,
  output logic [BAND_W-1:0] core_band,
  output logic [DATA_W-1:0] core_in,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_out,
  input  logic              cfg_we,
  input  logic [BAND_W-1:0] cfg_addr,
  input  logic [GAIN_W-1:0] cfg_gain,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              err_timeout,
  output logic              err_spurious,
  input  logic              err_clr
);
  state_t              state_reg, state_next;
  logic [BAND_W-1:0]   band_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic [DATA_W-1:0]   core_in_reg;
  logic [GAIN_W-1:0]   gain_live_reg   [N_BANDS];
  logic [GAIN_W-1:0]   gain_shadow_reg [N_BANDS];

  logic accept, in_wait, timeout_hit, band_step, last_band, emit;
  logic signed [DATA_W-1:0] out_data_s;

  assign accept      = in_valid && (state_reg == ST_IDLE);
  assign in_wait     = (state_reg == ST_WAIT);
  assign timeout_hit = in_wait && !core_done && (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));
  assign band_step   = in_wait && (core_done || timeout_hit);
  assign last_band   = (band_reg == BAND_W'(N_BANDS - 1));
  assign emit        = band_step && last_band;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        core_start = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (band_step)
          state_next = last_band ? ST_OUT : ST_ISSUE;
      end
      ST_OUT: begin
        out_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      band_reg     <= '0;
      wait_cnt_reg <= '0;
      core_in_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        core_in_reg <= in_data;
        band_reg    <= '0;
      end
      if (state_reg == ST_ISSUE)
        wait_cnt_reg <= '0;
      else if (in_wait && !band_step)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      if (band_step && !last_band)
        band_reg <= band_reg + 1'b1;
    end
  end

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (timeout_hit)
        err_timeout <= 1'b1;
      else if (err_clr)
        err_timeout <= 1'b0;
      if (core_done && !in_wait)
        err_spurious <= 1'b1;
      else if (err_clr)
        err_spurious <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < N_BANDS; gi++) begin : g_gain
      always_ff @(posedge clk) begin
        if (rst) begin
          gain_live_reg[gi]   <= GAIN_UNITY;
          gain_shadow_reg[gi] <= GAIN_UNITY;
        end else begin
          if (cfg_we && (cfg_addr == BAND_W'(gi)))
            gain_live_reg[gi] <= cfg_gain;
          if (accept)
            gain_shadow_reg[gi] <= gain_live_reg[gi];
        end
      end
    end
  endgenerate

  eq_gain_acc u_gain_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .add_en   (core_done && in_wait),
    .emit     (emit),
    .sample   ($signed(core_out)),
    .gain     (gain_shadow_reg[band_reg]),
    .out_data (out_data_s)
  );

  assign out_data  = out_data_s;
  assign core_band = band_reg;
  assign core_in   = core_in_reg;
endmodule

// File: tb/tb_eq_band_scheduler.sv
// Scoreboard bench for eq_band_scheduler with an echoing stub filter core.
module tb_eq_band_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        core_start;
  logic [2:0]  core_band;
  logic [15:0] core_in;
  logic        core_done = 1'b0;
  logic [15:0] core_out = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_gain = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        err_timeout;
  logic        err_spurious;
  logic        err_clr = 1'b0;

  eq_band_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_start(core_start), .core_band(core_band), .core_in(core_in),
    .core_done(core_done), .core_out(core_out), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_gain(cfg_gain), .out_valid(out_valid), .out_data(out_data),
    .err_timeout(err_timeout), .err_spurious(err_spurious), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct { int data; longint cyc; } exp_t;
  exp_t   sbq[$];
  int     nvec = 0;
  int     errs = 0;
  longint cyc = 0;
  int     g_live[8];
  int     lat = 1;
  int     skip_band = -1;
  longint due = -1;
  logic [15:0] due_data = '0;
  bit     spur_req = 0;
  int     unexpected = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub core: echoes core_in after lat cycles, never answers skip_band.
  always @(negedge clk)
    if (!rst && core_start && int'(core_band) != skip_band) begin
      due = cyc + lat;
      due_data = core_in;
    end

  always @(posedge clk) begin
    #1;
    if (due == cyc) begin
      core_done = 1'b1; core_out = due_data;
    end else if (spur_req) begin
      core_done = 1'b1; core_out = 16'h1234; spur_req = 0;
    end else begin
      core_done = 1'b0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output strobe must match the oldest expected frame, in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      nvec++;
      if (sbq.size() == 0) begin
        errs++; unexpected++;
        $display("FAIL unexpected_out: got out_data %0d at cycle %0d with no frame pending",
                 $signed(out_data), cyc);
      end else begin
        e = sbq.pop_front();
        if ($signed(out_data) != e.data || cyc != e.cyc) begin
          errs++;
          $display("FAIL frame_out: got %0d at cycle %0d expected %0d at cycle %0d",
                   $signed(out_data), cyc, e.data, e.cyc);
        end else begin
          $display("frame out %0d at cycle %0d ok", e.data, cyc);
        end
      end
    end
  end

  // Reference: sum of echoed sample times gain over answered bands, floor /64, clamp.
  task automatic push_expect(input int din, input longint t);
    exp_t   e;
    longint s = 0;
    longint q;
    longint cost = 0;
    for (int b = 0; b < 8; b++) begin
      if (b != skip_band) begin
        s += longint'(din) * g_live[b];
        cost += lat + 1;
      end else begin
        cost += 64;
      end
    end
    q = s / 64;
    if (s < 0 && (s % 64) != 0) q -= 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    e.data = int'(q);
    e.cyc  = t + 1 + cost;
    sbq.push_back(e);
  endtask

  task automatic send(input int din, input bit expect_out);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'(din);
    @(negedge clk);
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_wait_expired", 0, 1);
    else if (expect_out) push_expect(din, cyc);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int gain);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_gain = 8'(gain);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    g_live[addr] = gain;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      chk("drain_wait_expired", sbq.size(), 0);
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int     n;
    int     acc_cnt;
    longint last;
    logic [15:0] prev;
    for (int b = 0; b < 8; b++) g_live[b] = 64;

    // Reset and defaults
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_err_spurious", err_spurious, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_band", core_band, 0);
    chk("rst_core_in", core_in, 0);

    // L=1 latency and issue pattern
    lat = 1;
    send(1000, 1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("core_start_pattern", core_start, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 1) chk("core_band_seq", core_band, (k - 1) / 2);
    end
    drain();

    lat = 4;
    send(1000, 1);
    drain();
    lat = 1;

    // Saturation
    send(20000, 1);  drain();
    send(-20000, 1); drain();
    for (int b = 0; b < 8; b++) cfg_write(b, 0);
    send(12345, 1);  drain();

    // Mid-frame config
    for (int b = 0; b < 8; b++) cfg_write(b, 64);
    send(1000, 1);
    cfg_write(3, 0);
    drain();
    send(1000, 1); drain();
    cfg_write(0, 255);
    for (int b = 1; b < 8; b++) cfg_write(b, 0);
    send(64, 1); drain();
    for (int b = 0; b < 8; b++) cfg_write(b, 64);

    // Timeout on band 5
    skip_band = 5;
    send(1000, 1); drain();
    chk("err_timeout_set", err_timeout, 1);
    skip_band = -1;
    send(1000, 1); drain();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_timeout_clr", err_timeout, 0);

    // in_valid held: one accept per frame, fixed gap
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'd500;
    acc_cnt = 0; last = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (last >= 0) chk("accept_gap", cyc - last, 8 * (lat + 1) + 2);
        push_expect(500, cyc);
        last = cyc;
        acc_cnt++;
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    chk("held_accepts", acc_cnt, 4);
    drain();

    // Spurious done in IDLE
    prev = out_data;
    spur_req = 1;
    repeat (3) @(negedge clk);
    chk("err_spurious_set", err_spurious, 1);
    chk("spur_out_hold", out_data, prev);
    send(-777, 1); drain();

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      lat = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 1) cfg_write($urandom_range(0, 7), $urandom_range(0, 255));
      send(int'($signed(16'($urandom))), 1);
      if ($urandom_range(0, 2) == 0) cfg_write($urandom_range(0, 7), $urandom_range(0, 255));
      drain();
    end

    // Reset mid-frame at band 4
    lat = 1;
    send(1000, 0);
    n = 0;
    @(negedge clk);
    while (!(core_start && core_band == 3'd4) && n < 100) begin @(negedge clk); n++; end
    chk("band4_reached", (core_start && core_band == 3'd4) ? 1 : 0, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int b = 0; b < 8; b++) g_live[b] = 64;
    @(negedge clk);
    chk("rst_mid_idle", in_ready, 1);
    chk("rst_mid_no_start", core_start, 0);
    repeat (30) @(negedge clk);
    chk("rst_mid_no_out", unexpected, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got no finish expected finish before limit");
    $fatal(1, "time limit");
  end
endmodule
